// File: rtl/gb_pkg.sv
// Shared constants for the register-trace checker: FSM states, stop opcode and
// snapshot lane order (lane index 7 sits in the MSBs of a snapshot).
package gb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  localparam logic [7:0] GB_STOP_OP = 8'h10;
  localparam int         GB_LANES   = 8;

  localparam int LANE_A = 7;
  localparam int LANE_B = 6;
  localparam int LANE_C = 5;
  localparam int LANE_D = 4;
  localparam int LANE_E = 3;
  localparam int LANE_H = 2;
  localparam int LANE_L = 1;
  localparam int LANE_F = 0;

endpackage

// File: rtl/reg_trace_checker_vec_ram.sv
// Vector store: single address port, synchronous write, registered read.
// Latency: read data appears 1 cycle after re; contents are never reset.
// Backpressure: none; the owner never asserts we and re in the same cycle.
module vec_ram #(
  parameter int AW = 10,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/reg_trace_checker.sv
// Register-trace checker: steps a vector memory per fetch, compares snapshots per instruction end.
// Latency: vector read 1 cycle, results 1 cycle after instr_done; lane mask via REG_TRACE_CHECKER_MASK_EN.
// Backpressure: none; hold suppresses fetches, vector writes are dropped while busy.
module reg_trace_checker
  import gb_pkg::*;
#(
  parameter int                 OP_SIZE   = 8,
  parameter int                 DATA_SIZE = 8,
  parameter int                 LANES     = GB_LANES,
  parameter int                 VEC_AW    = 10,
  parameter int                 CNT_W     = 32,
  parameter logic [OP_SIZE-1:0] STOP_OP   = GB_STOP_OP,
  localparam int                RES_SIZE  = LANES * DATA_SIZE,
`ifdef REG_TRACE_CHECKER_MASK_EN
  localparam int                MASK_W    = LANES,
`else
  localparam int                MASK_W    = 0,
`endif
  localparam int                VEC_W     = MASK_W + 1 + OP_SIZE + RES_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                instr_start,
  input  logic                hold,
  input  logic [OP_SIZE-1:0]  fetch_op,
  input  logic                instr_done,
  input  logic [RES_SIZE-1:0] res,
  input  logic                vec_we,
  input  logic [VEC_AW-1:0]   vec_addr,
  input  logic [VEC_W-1:0]    vec_wdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    check_count,
  output logic                first_err_valid,
  output logic [VEC_AW-1:0]   first_err_index,
  output logic [RES_SIZE-1:0] first_err_diff,
  output logic [OP_SIZE-1:0]  first_err_op,
  output logic                overrun
);

  localparam int                VALID_BIT = RES_SIZE + OP_SIZE;
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [VEC_AW-1:0] PTR_ONE   = {{(VEC_AW-1){1'b0}}, 1'b1};
  localparam logic [VEC_AW-1:0] PTR_MAX   = {VEC_AW{1'b1}};

  trace_state_t        state;
  logic [VEC_AW-1:0]   vec_ptr;
  logic [VEC_AW-1:0]   rd_index;
  logic [VEC_AW-1:0]   cur_index;
  logic                rd_vld;
  logic                cur_valid;
  logic [OP_SIZE-1:0]  cur_op;
  logic [RES_SIZE-1:0] cur_exp;
  logic [RES_SIZE-1:0] care;
  logic [RES_SIZE-1:0] diff;
  logic [VEC_W-1:0]    ram_q;
  logic                idle_or_done;
  logic                fetch_acc;
  logic                do_check;
  logic                mismatch;

  assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);

  // A STOP fetch before the run has started is not a real instruction boundary.
  assign fetch_acc = instr_start && !hold && !arm &&
                     ((state == ST_RUN) || ((state == ST_ARMED) && (fetch_op != STOP_OP)));
  assign do_check  = instr_done && (state == ST_RUN) && cur_valid;

  vec_ram #(
    .AW (VEC_AW),
    .W  (VEC_W)
  ) u_vec_ram (
    .clk   (clk),
    .we    (vec_we && idle_or_done),
    .re    (fetch_acc),
    .addr  (fetch_acc ? vec_ptr : vec_addr),
    .wdata (vec_wdata),
    .rdata (ram_q)
  );

`ifdef REG_TRACE_CHECKER_MASK_EN
  logic [MASK_W-1:0] cur_mask;

  always_comb begin
    care = '0;
    for (int l = 0; l < LANES; l++) begin
      care[l*DATA_SIZE +: DATA_SIZE] = {DATA_SIZE{~cur_mask[l]}};
    end
  end
`else
  assign care = '1;
`endif

  assign diff     = (res ^ cur_exp) & care;
  assign mismatch = |diff;

  assign busy = (state == ST_ARMED) || (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0) && !overrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      vec_ptr         <= '0;
      rd_index        <= '0;
      rd_vld          <= 1'b0;
      cur_valid       <= 1'b0;
      cur_index       <= '0;
      cur_op          <= '0;
      cur_exp         <= '0;
`ifdef REG_TRACE_CHECKER_MASK_EN
      cur_mask        <= '0;
`endif
      err_count       <= '0;
      check_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_index <= '0;
      first_err_diff  <= '0;
      first_err_op    <= '0;
      overrun         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            vec_ptr         <= '0;
            rd_vld          <= 1'b0;
            cur_valid       <= 1'b0;
            err_count       <= '0;
            check_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_index <= '0;
            first_err_diff  <= '0;
            first_err_op    <= '0;
            overrun         <= 1'b0;
            state           <= ST_ARMED;
          end
        end
        ST_ARMED: if (fetch_acc) state <= ST_RUN;
        ST_RUN:   if (fetch_acc && (fetch_op == STOP_OP)) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase

      // The word read at the previous fetch becomes current now: one-instruction lag.
      if (fetch_acc) begin
        vec_ptr   <= vec_ptr + PTR_ONE;
        if (vec_ptr == PTR_MAX) overrun <= 1'b1;
        rd_index  <= vec_ptr;
        rd_vld    <= 1'b1;
        cur_valid <= rd_vld && ram_q[VALID_BIT];
        cur_index <= rd_index;
        cur_op    <= ram_q[RES_SIZE +: OP_SIZE];
        cur_exp   <= ram_q[RES_SIZE-1:0];
`ifdef REG_TRACE_CHECKER_MASK_EN
        cur_mask  <= ram_q[VEC_W-1 -: MASK_W];
`endif
      end

      if (do_check) begin
        if (check_count != CNT_MAX) check_count <= check_count + CNT_ONE;
        if (mismatch) begin
          if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_index <= cur_index;
            first_err_op    <= cur_op;
            first_err_diff  <= diff;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_trace_checker.sv
// Self-checking bench for reg_trace_checker: directed and randomized programs vs a vector-level model.
// A second instance with a 4-entry memory sees the same stimulus to exercise pointer wrap.
module tb_reg_trace_checker;
  import gb_pkg::*;

  localparam int OPW  = 8;
  localparam int RW   = 64;
  localparam int AW   = 10;
  localparam int AW_S = 2;
`ifdef REG_TRACE_CHECKER_MASK_EN
  localparam int MW      = 8;
  localparam bit MASK_ON = 1'b1;
`else
  localparam int MW      = 0;
  localparam bit MASK_ON = 1'b0;
`endif
  localparam int VW = MW + 1 + OPW + RW;
  localparam logic [7:0] STOP = 8'h10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic          instr_start = 1'b0;
  logic          hold = 1'b0;
  logic          instr_done = 1'b0;
  logic          vec_we = 1'b0;
  logic [7:0]    fetch_op = 8'h00;
  logic [63:0]   res = 64'd0;
  logic [AW-1:0] vec_addr = '0;
  logic [VW-1:0] vec_wdata = '0;

  logic          busy, done, pass, first_err_valid, overrun;
  logic [31:0]   err_count, check_count;
  logic [AW-1:0] first_err_index;
  logic [63:0]   first_err_diff;
  logic [7:0]    first_err_op;

  logic            busy_s, done_s, pass_s, first_err_valid_s, overrun_s;
  logic [31:0]     err_count_s, check_count_s;
  logic [AW_S-1:0] first_err_index_s;
  logic [63:0]     first_err_diff_s;
  logic [7:0]      first_err_op_s;

  always #5 clk = ~clk;

  reg_trace_checker dut (
    .clk(clk), .rst(rst), .arm(arm), .instr_start(instr_start), .hold(hold),
    .fetch_op(fetch_op), .instr_done(instr_done), .res(res),
    .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .check_count(check_count),
    .first_err_valid(first_err_valid), .first_err_index(first_err_index),
    .first_err_diff(first_err_diff), .first_err_op(first_err_op), .overrun(overrun)
  );

  reg_trace_checker #(.VEC_AW(AW_S)) dut_s (
    .clk(clk), .rst(rst), .arm(arm), .instr_start(instr_start), .hold(hold),
    .fetch_op(fetch_op), .instr_done(instr_done), .res(res),
    .vec_we(vec_we), .vec_addr(vec_addr[AW_S-1:0]), .vec_wdata(vec_wdata),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s), .check_count(check_count_s),
    .first_err_valid(first_err_valid_s), .first_err_index(first_err_index_s),
    .first_err_diff(first_err_diff_s), .first_err_op(first_err_op_s), .overrun(overrun_s)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model memory and program
  bit          mv_valid [16];
  logic [7:0]  mv_op    [16];
  logic [63:0] mv_exp   [16];
  logic [7:0]  mv_mask  [16];
  logic [7:0]  prog_op  [16];
  logic [63:0] prog_res [16];
  int          run_chk  [16];
  int          run_err  [16];

  int          m_check, m_err;
  bit          m_fv, m_over_s;
  logic [AW-1:0] m_fidx;
  logic [7:0]  m_fop;
  logic [63:0] m_fdiff;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] make_word(input int a);
`ifdef REG_TRACE_CHECKER_MASK_EN
    return {mv_mask[a], mv_valid[a], mv_op[a], mv_exp[a]};
`else
    return {mv_valid[a], mv_op[a], mv_exp[a]};
`endif
  endfunction

  function automatic logic [63:0] lane_diff(input logic [63:0] r, input logic [63:0] e,
                                            input logic [7:0] m);
    logic [63:0] d;
    d = r ^ e;
    for (int l = 0; l < 8; l++) if (MASK_ON && m[l]) d[l*8 +: 8] = 8'h00;
    return d;
  endfunction

  // Instruction i (i>=1) ends against vector i-1; instruction 0 has nothing to compare.
  task automatic compute_model(input int n);
    logic [63:0] d;
    m_check = 0; m_err = 0; m_fv = 1'b0; m_fidx = '0; m_fop = '0; m_fdiff = '0;
    run_chk[0] = 0; run_err[0] = 0;
    for (int i = 1; i < n; i++) begin
      if (mv_valid[i-1]) begin
        m_check++;
        d = lane_diff(prog_res[i], mv_exp[i-1], mv_mask[i-1]);
        if (d != 64'd0) begin
          if (!m_fv) begin
            m_fv = 1'b1; m_fidx = AW'(i-1); m_fop = mv_op[i-1]; m_fdiff = d;
          end
          m_err++;
        end
      end
      run_chk[i] = m_check;
      run_err[i] = m_err;
    end
    m_over_s = (n + 1) >= 4;
  endtask

  task automatic load_vectors(input int cnt);
    for (int a = 0; a < cnt; a++) begin
      vec_we = 1'b1; vec_addr = AW'(a); vec_wdata = make_word(a);
      cyc();
    end
    vec_we = 1'b0;
    cyc();
  endtask

  task automatic setup_base();
    for (int a = 0; a < 16; a++) begin
      mv_valid[a] = 1'b0; mv_op[a] = 8'h00; mv_exp[a] = 64'd0; mv_mask[a] = 8'h00;
    end
    mv_valid[0] = 1'b1; mv_op[0] = 8'h00; mv_exp[0] = 64'h0100_1300_D801_4DB0;
    mv_valid[1] = 1'b1; mv_op[1] = 8'h06; mv_exp[1] = 64'h0105_1300_D801_4DB0;
    mv_valid[2] = 1'b1; mv_op[2] = 8'h0E; mv_exp[2] = 64'h0105_0700_D801_4DB0;
    prog_op[0] = 8'h00; prog_res[0] = 64'h0100_1300_D801_4DB0;
    prog_op[1] = 8'h06; prog_res[1] = mv_exp[0];
    prog_op[2] = 8'h0E; prog_res[2] = mv_exp[1];
    prog_op[3] = 8'h00; prog_res[3] = mv_exp[2];
    prog_op[4] = 8'h00; prog_res[4] = mv_exp[2];
  endtask

  task automatic run_prog(input int n, input int ovl_pct, input bit hold_p, input bit sp_we,
                          input bit arm_f, input bit stop_a, input string tag);
    int done_idx;
    bit pend;
    compute_model(n);
    arm = 1'b1;
    if (arm_f) begin instr_start = 1'b1; fetch_op = 8'h3E; end
    cyc();
    arm = 1'b0; instr_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_arm: got %0b want 1", tag, busy); else n_pass++;
    if (stop_a) begin
      instr_start = 1'b1; fetch_op = STOP; cyc(); instr_start = 1'b0; cyc();
    end
    pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      instr_start = 1'b1; fetch_op = prog_op[i]; done_idx = -1;
      if (pend) begin instr_done = 1'b1; res = prog_res[i-1]; done_idx = i - 1; end
      cyc();
      instr_start = 1'b0; instr_done = 1'b0;
      if (done_idx >= 0) begin
        n_checks++;
        if (check_count !== 32'(run_chk[done_idx]) || err_count !== 32'(run_err[done_idx]))
          $display("FAIL %s running_counts[%0d]: got %0d/%0d want %0d/%0d", tag, done_idx,
                   check_count, err_count, run_chk[done_idx], run_err[done_idx]);
        else n_pass++;
      end
      if (sp_we && i == 0) begin
        vec_we = 1'b1; vec_addr = AW'(1); vec_wdata = '0;
        vec_wdata[RW-1:0] = ~mv_exp[1]; vec_wdata[RW+OPW] = 1'b1;
      end
      cyc();
      vec_we = 1'b0;
      if (hold_p) begin
        hold = 1'b1; instr_start = 1'b1; fetch_op = 8'($urandom);
        cyc();
        instr_start = 1'b0; hold = 1'b0;
        cyc();
      end
      if (int'($urandom_range(99)) < ovl_pct) pend = 1'b1;
      else begin
        pend = 1'b0;
        instr_done = 1'b1; res = prog_res[i];
        cyc();
        instr_done = 1'b0;
        n_checks++;
        if (check_count !== 32'(run_chk[i]) || err_count !== 32'(run_err[i]))
          $display("FAIL %s running_counts[%0d]: got %0d/%0d want %0d/%0d", tag, i,
                   check_count, err_count, run_chk[i], run_err[i]);
        else n_pass++;
        cyc();
      end
    end
    instr_start = 1'b1; fetch_op = STOP;
    if (pend) begin instr_done = 1'b1; res = prog_res[n-1]; end
    n_checks++;
    if (done !== 1'b0) $display("FAIL %s done_before_stop_edge: got %0b want 0", tag, done); else n_pass++;
    cyc();
    instr_start = 1'b0; instr_done = 1'b0;
    n_checks++;
    if (done !== 1'b1) $display("FAIL %s done_after_stop: got %0b want 1", tag, done); else n_pass++;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || pass !== (m_err == 0) || overrun !== 1'b0)
      $display("FAIL %s busy/pass/overrun: got %0b/%0b/%0b want 0/%0b/0", tag, busy, pass, overrun, m_err == 0);
    else n_pass++;
    n_checks++;
    if (check_count !== 32'(m_check) || err_count !== 32'(m_err))
      $display("FAIL %s final_counts: got %0d/%0d want %0d/%0d", tag, check_count, err_count, m_check, m_err);
    else n_pass++;
    n_checks++;
    if (first_err_valid !== m_fv || first_err_index !== m_fidx || first_err_op !== m_fop ||
        first_err_diff !== m_fdiff)
      $display("FAIL %s first_err: got %0b/%0d/%h/%h want %0b/%0d/%h/%h", tag, first_err_valid,
               first_err_index, first_err_op, first_err_diff, m_fv, m_fidx, m_fop, m_fdiff);
    else n_pass++;
    n_checks++;
    if (overrun_s !== m_over_s)
      $display("FAIL %s small_overrun: got %0b want %0b", tag, overrun_s, m_over_s);
    else n_pass++;
    if (m_over_s) begin
      n_checks++;
      if (pass_s !== 1'b0) $display("FAIL %s small_pass: got %0b want 0", tag, pass_s); else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(); cyc();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || overrun !== 1'b0 || first_err_valid !== 1'b0)
      $display("FAIL reset_flags: got %0b%0b%0b%0b%0b want 00000", busy, done, pass, overrun, first_err_valid);
    else n_pass++;
    n_checks++;
    if (err_count !== 32'd0 || check_count !== 32'd0 || first_err_diff !== 64'd0 ||
        first_err_index !== '0 || first_err_op !== 8'd0)
      $display("FAIL reset_values: got %0d/%0d/%h want 0/0/0", err_count, check_count, first_err_diff);
    else n_pass++;
    rst = 1'b1;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_reset: got busy %0b done %0b want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_nop_ld();
    setup_base(); load_vectors(6);
    run_prog(4, 0, 1'b0, 1'b0, 1'b0, 1'b0, "nop_ld");
    n_checks++;
    if (pass !== 1'b1 || check_count !== 32'd3 || err_count !== 32'd0)
      $display("FAIL nop_ld_const: got pass %0b chk %0d err %0d want 1 3 0", pass, check_count, err_count);
    else n_pass++;
  endtask

  task automatic test_lane_b_err();
    setup_base(); load_vectors(6);
    prog_res[2] = 64'h0104_1300_D801_4DB0;
    run_prog(4, 0, 1'b0, 1'b0, 1'b0, 1'b0, "lane_b");
    n_checks++;
    if (err_count !== 32'd1 || first_err_index !== AW'(1) || first_err_diff !== 64'h0001_0000_0000_0000)
      $display("FAIL lane_b_const: got err %0d idx %0d diff %h want 1 1 0001000000000000",
               err_count, first_err_index, first_err_diff);
    else n_pass++;
  endtask

  task automatic test_two_errs(input bit with_hold, input string tag);
    setup_base(); load_vectors(6);
    prog_res[2] = 64'h0104_1300_D801_4DB0;
    prog_res[3] = mv_exp[2] ^ 64'h0000_0000_0000_0100;
    run_prog(4, 0, with_hold, 1'b0, 1'b0, 1'b0, tag);
    n_checks++;
    if (err_count !== 32'd2 || first_err_index !== AW'(1) || first_err_op !== 8'h06)
      $display("FAIL %s two_err_const: got err %0d idx %0d op %h want 2 1 06", tag,
               err_count, first_err_index, first_err_op);
    else n_pass++;
  endtask

  task automatic test_overrun();
    setup_base(); load_vectors(6);
    run_prog(2, 0, 1'b0, 1'b0, 1'b0, 1'b0, "ovr_n2");
    n_checks++;
    if (overrun_s !== 1'b0) $display("FAIL ovr_n2_const: got %0b want 0", overrun_s); else n_pass++;
    run_prog(3, 50, 1'b0, 1'b0, 1'b0, 1'b0, "ovr_n3");
    n_checks++;
    if (overrun_s !== 1'b1) $display("FAIL ovr_n3_const: got %0b want 1", overrun_s); else n_pass++;
    run_prog(5, 0, 1'b0, 1'b0, 1'b0, 1'b0, "ovr_n5");
    n_checks++;
    if (overrun_s !== 1'b1 || pass_s !== 1'b0)
      $display("FAIL ovr_n5_const: got overrun %0b pass %0b want 1 0", overrun_s, pass_s);
    else n_pass++;
  endtask

  task automatic test_mask();
    setup_base();
    mv_mask[2] = 8'h01;
    load_vectors(6);
    prog_res[3] = mv_exp[2] ^ 64'h0000_0000_0000_00FF;
    run_prog(4, 0, 1'b0, 1'b0, 1'b0, 1'b0, "mask_f");
    n_checks++;
    if (err_count !== (MASK_ON ? 32'd0 : 32'd1))
      $display("FAIL mask_f_const: got err %0d want %0d", err_count, MASK_ON ? 0 : 1);
    else n_pass++;
  endtask

  task automatic test_collisions();
    setup_base(); load_vectors(6);
    run_prog(4, 100, 1'b1, 1'b1, 1'b1, 1'b1, "collide");
    n_checks++;
    if (pass !== 1'b1 || check_count !== 32'd3)
      $display("FAIL collide_const: got pass %0b chk %0d want 1 3", pass, check_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    setup_base(); load_vectors(6);
    arm = 1'b1; cyc(); arm = 1'b0;
    instr_start = 1'b1; fetch_op = 8'h00; cyc(); instr_start = 1'b0; cyc();
    instr_done = 1'b1; res = prog_res[0]; cyc(); instr_done = 1'b0; cyc();
    instr_start = 1'b1; fetch_op = 8'h06; cyc(); instr_start = 1'b0; cyc();
    instr_done = 1'b1; res = prog_res[1]; cyc(); instr_done = 1'b0;
    n_checks++;
    if (check_count !== 32'd1 || busy !== 1'b1)
      $display("FAIL midrun_state: got chk %0d busy %0b want 1 1", check_count, busy);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || check_count !== 32'd0 || done !== 1'b0)
      $display("FAIL async_reset: got busy %0b chk %0d done %0b want 0 0 0", busy, check_count, done);
    else n_pass++;
    cyc();
    rst = 1'b1;
    cyc();
    // Memory contents survive reset, so no reload here.
    run_prog(4, 30, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 30; r++) begin
      n = int'($urandom_range(2, 10));
      for (int a = 0; a < 16; a++) begin
        mv_valid[a] = ($urandom_range(3) != 0);
        mv_op[a]    = 8'($urandom);
        mv_exp[a]   = {$urandom, $urandom};
        mv_mask[a]  = 8'($urandom & $urandom & $urandom);
      end
      for (int i = 0; i < n; i++) begin
        prog_op[i] = 8'($urandom);
        if (prog_op[i] == STOP) prog_op[i] = 8'h00;
        if (i == 0) prog_res[i] = {$urandom, $urandom};
        else if ($urandom_range(1) == 0) prog_res[i] = mv_exp[i-1];
        else prog_res[i] = mv_exp[i-1] ^ (64'($urandom_range(1, 255)) << (8 * $urandom_range(7)));
      end
      load_vectors(n + 2);
      run_prog(n, int'($urandom_range(100)), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_nop_ld();
    test_lane_b_err();
    test_two_errs(1'b0, "two_err");
    test_two_errs(1'b1, "two_err_hold");
    test_overrun();
    test_mask();
    test_collisions();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_trace_checker.md
# reg_trace_checker

Synthesizable, parametrised register-trace checker that replaces the simulation-only vector comparison done around the CPU core. It holds a loadable vector memory of {opcode, expected register snapshot} entries, steps through it at each instruction fetch, compares the expected snapshot with the live register-file snapshot at each instruction end, counts errors and captures the first mismatch. It halts on a configurable stop opcode, so it can run on FPGA hardware or in any bench alongside `top`.

## Interface
- `OP_SIZE`, 8, opcode width stored per vector.
- `DATA_SIZE`, 8, width of one register lane.
- `LANES`, 8, register lanes per snapshot (A,B,C,D,E,H,L,F, MSB lane first); `RES_SIZE = LANES*DATA_SIZE`.
- `VEC_AW`, 10, vector memory address width; depth `2**VEC_AW`.
- `CNT_W`, 32, width of all counters.
- `STOP_OP`, 8'h10, opcode that terminates a run.
- `clk` in 1 system clock.
- `rst` in 1 asynchronous, active-low reset.
- `arm` in 1 one-cycle pulse; starts a run from IDLE or DONE.
- `instr_start` in 1 one-cycle pulse at M1/T1 of each instruction fetch.
- `hold` in 1 decoder hold; when high, `instr_start` is ignored.
- `fetch_op` in OP_SIZE opcode on the data bus at `instr_start`.
- `instr_done` in 1 one-cycle pulse on the last T-cycle of the last M-cycle.
- `res` in RES_SIZE live register snapshot.
- `vec_we` in 1, `vec_addr` in VEC_AW, `vec_wdata` in 1+OP_SIZE+RES_SIZE (+RES_SIZE/DATA_SIZE mask bits, see Configuration): vector load port; word = {valid, op, expected}.
- `busy` out 1 high in ARMED or RUN.
- `done` out 1 high in DONE.
- `pass` out 1 `done && err_count==0 && !overrun`.
- `err_count`, `check_count` out CNT_W.
- `first_err_valid` out 1, `first_err_index` out VEC_AW, `first_err_diff` out RES_SIZE (res XOR expected).
- `first_err_op` out OP_SIZE.
- `overrun` out 1 sticky; vector pointer wrapped.

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset -> IDLE.
- IDLE/DONE + `arm`: clear counters, first-error capture, `overrun`, `vec_ptr`, `cur_valid`; -> ARMED.
- ARMED: on accepted fetch (`instr_start && !hold`), if `fetch_op != STOP_OP`, -> RUN (mirrors "running" latch). A STOP fetch in ARMED is ignored.
- RUN: on an accepted fetch with `fetch_op == STOP_OP` -> DONE. A compare in that same cycle is still performed.
- Vector pipeline: each accepted fetch in ARMED/RUN issues a synchronous read of `vec_mem[vec_ptr]`. The result loads into `cur_vec` and `cur_index` at the next accepted fetch, giving a one-instruction lag. `vec_ptr` increments modulo depth; wrap to 0 sets `overrun`.
- Compare: on `instr_done` in RUN with `cur_vec.valid`: `check_count`++. If `res != expected`, `err_count`++. On the first error only, capture index, op and diff.
- Invalid entries (valid=0) are skipped. This replaces the X-check.
- Counters saturate at all-ones.
- `vec_we` is honoured only in IDLE/DONE; ignored otherwise.

## Timing
- All outputs reset to 0.
- Memory read latency: 1 cycle. `instr_start` pulses must be ≥2 cycles apart.
- `instr_done` and `instr_start` in the same cycle: the compare uses `cur_vec` before update.
- Counters and first-error outputs update 1 cycle after `instr_done`.
- `done` rises 1 cycle after the STOP fetch.
- `arm` and `instr_start` in the same cycle: `arm` wins; the fetch is ignored.
- Asynchronous reset mid-run: immediately IDLE. Vector memory contents are not reset.

## Configuration
- `REG_TRACE_CHECKER_MASK_EN` defined:
  - each vector word carries a LANES-bit don't-care mask (1 = ignore lane), as MSBs of `vec_wdata`;
  - masked lanes are excluded from the compare and zeroed in `first_err_diff`.
- Not defined:
  - no mask bits exist in `vec_wdata` or memory;
  - every lane is compared.

## Structure
- Shared package `gb_pkg`: state enum, `STOP_OP` default, lane order constants (A..F) and lane count.
- One sub-module: `vec_ram`, a single-port synchronous RAM (write port, registered read).

## Test plan
- Load 3 valid vectors matching a NOP/LD sequence, arm, run to STOP 0x10 -> `done`=1, `pass`=1, `check_count`=3, `err_count`=0.
- Corrupt lane B of vector 1 (0x05 expected, core gives 0x04) -> `err_count`=1, `first_err_index`=1, `first_err_diff`=64'h0001_0000_0000_0000.
- Two mismatches (indices 1 and 2) -> `err_count`=2; first-error fields still index 1.
- Hold asserted across a fetch -> `vec_ptr` not advanced; the compare sequence is unchanged versus the no-hold run.
- VEC_AW=2, 5 instructions -> `overrun`=1, `pass`=0.
- With `REG_TRACE_CHECKER_MASK_EN`, mask the F lane and mismatch F only -> `err_count`=0. Without the macro -> `err_count`=1.
